// File: rtl/present_uut_driver.sv
// Sequencer that runs one PRESENT operation per request: it resets the core, waits for
// the key schedule and the end flag for the requested direction, then returns the
// result block, the cycle count and a timeout flag.
module present_uut_driver #(
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 4096,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [63:0]      block_i,
   input  logic [79:0]      key_i,
   input  logic             enc_dec_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [63:0]      block_o,
   output logic [CNT_W-1:0] cycles_o,
   output logic             timeout_o,
   output logic             uut_rst_o,
   output logic [63:0]      uut_block_o,
   output logic [79:0]      uut_key_o,
   output logic             uut_enc_dec_o,
   input  logic             uut_end_key_i,
   input  logic [63:0]      uut_block_i,
   input  logic             uut_end_enc_i,
   input  logic             uut_end_dec_i
);

   // state  | meaning
   // IDLE   | waiting for a request, core held in reset
   // RSTUUT | core held in reset for RST_CYCLES cycles
   // KEYGEN | core running, waiting for end of key schedule
   // RUN    | core running, waiting for the matching end flag
   // DONE   | response presented until consumed, core held in reset
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RSTUUT = 3'd1,
      KEYGEN = 3'd2,
      RUN    = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0]    RST_LOAD = RW'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);

   state_t            state;
   state_t            state_nxt;
   logic [RW-1:0]     rst_cnt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic              accept;
   logic              counting;
   logic              end_match;
   logic              complete;
   logic              expire;

   assign accept    = req_valid_i && (state == IDLE);
   assign counting  = (state == KEYGEN) || (state == RUN);
   assign cnt_inc   = cnt + CNT_W'(1);
   // the flag for the other direction is never looked at
   assign end_match = uut_enc_dec_o ? uut_end_dec_i : uut_end_enc_i;
   assign complete  = ((state == RUN) && end_match) ||
                      ((state == KEYGEN) && uut_end_key_i && end_match);
   assign expire    = counting && (cnt_inc == TMO) && !complete;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RSTUUT;
         RSTUUT:  if (rst_cnt == '0) state_nxt = KEYGEN;
         KEYGEN: begin
            if (complete || expire) state_nxt = DONE;
            else if (uut_end_key_i) state_nxt = RUN;
         end
         RUN:     if (complete || expire) state_nxt = DONE;
         DONE:    if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      uut_rst_o   = 1'b1;
      case (state)
         IDLE:    req_ready_o = 1'b1;
         KEYGEN:  uut_rst_o   = 1'b0;
         RUN:     uut_rst_o   = 1'b0;
         DONE:    rsp_valid_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_cnt       <= '0;
         cnt           <= '0;
         block_o       <= '0;
         cycles_o      <= '0;
         timeout_o     <= 1'b0;
         uut_block_o   <= '0;
         uut_key_o     <= '0;
         uut_enc_dec_o <= 1'b0;
      end else begin
         if (accept) begin
            uut_block_o   <= block_i;
            uut_key_o     <= key_i;
            uut_enc_dec_o <= enc_dec_i;
            cnt           <= '0;
            rst_cnt       <= RST_LOAD;
         end
         if ((state == RSTUUT) && (rst_cnt != '0)) begin
            rst_cnt <= rst_cnt - RW'(1);
         end
         if (counting) begin
            cnt <= cnt_inc;
         end
         if (complete) begin
            block_o   <= uut_block_i;
            cycles_o  <= cnt_inc;
            timeout_o <= 1'b0;
         end else if (expire) begin
            block_o   <= '0;
            cycles_o  <= TMO;
            timeout_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_present_uut_driver.sv
// Bench for present_uut_driver: a behavioural PRESENT-80 core stub with programmable
// latencies, table vectors, random transactions and multi-cycle corner sequences.
module tb_present_uut_driver;

   localparam int RST_CYCLES = 2;
   localparam int TIMEOUT    = 16;
   localparam int CNT_W      = 16;
   localparam logic [63:0] SB_TAB = 64'h2174_8FE3_DA09_B65C;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid_i;
   logic             req_ready_o;
   logic [63:0]      block_i;
   logic [79:0]      key_i;
   logic             enc_dec_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [63:0]      block_o;
   logic [CNT_W-1:0] cycles_o;
   logic             timeout_o;
   logic             uut_rst_o;
   logic [63:0]      uut_block_o;
   logic [79:0]      uut_key_o;
   logic             uut_enc_dec_o;
   logic             uut_end_key_i;
   logic [63:0]      uut_block_i;
   logic             uut_end_enc_i;
   logic             uut_end_dec_i;

   int checks   = 0;
   int failures = 0;

   present_uut_driver #(.RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .block_i(block_i), .key_i(key_i), .enc_dec_i(enc_dec_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .block_o(block_o), .cycles_o(cycles_o), .timeout_o(timeout_o),
      .uut_rst_o(uut_rst_o), .uut_block_o(uut_block_o), .uut_key_o(uut_key_o),
      .uut_enc_dec_o(uut_enc_dec_o), .uut_end_key_i(uut_end_key_i),
      .uut_block_i(uut_block_i), .uut_end_enc_i(uut_end_enc_i),
      .uut_end_dec_i(uut_end_dec_i)
   );

   always #5 clk = ~clk;

   // ---------------- PRESENT-80 reference ----------------
   function automatic logic [3:0] sb(input logic [3:0] x);
      logic [63:0] t;
      t = SB_TAB;
      return t[4*x +: 4];
   endfunction

   function automatic logic [3:0] sb_inv(input logic [3:0] x);
      logic [3:0] r;
      r = '0;
      for (int v = 0; v < 16; v++) if (sb(4'(v)) == x) r = 4'(v);
      return r;
   endfunction

   function automatic logic [63:0] present_ref(input logic [63:0] blk, input logic [79:0] key,
                                               input logic dir);
      logic [63:0] rk [1:32];
      logic [79:0] k;
      logic [63:0] s;
      logic [63:0] o;
      k = key;
      for (int i = 1; i <= 32; i++) begin
         rk[i] = k[79:16];
         k = {k[18:0], k[79:19]};
         k[79:76] = sb(k[79:76]);
         k[19:15] = k[19:15] ^ 5'(i);
      end
      if (!dir) begin
         s = blk;
         for (int r = 1; r <= 31; r++) begin
            s = s ^ rk[r];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
            o = '0;
            for (int b = 0; b < 63; b++) o[(b * 16) % 63] = s[b];
            o[63] = s[63];
            s = o;
         end
         s = s ^ rk[32];
      end else begin
         s = blk ^ rk[32];
         for (int r = 31; r >= 1; r--) begin
            o = '0;
            for (int b = 0; b < 63; b++) o[b] = s[(b * 16) % 63];
            o[63] = s[63];
            s = o;
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb_inv(s[4*n +: 4]);
            s = s ^ rk[r];
         end
      end
      return s;
   endfunction

   // ---------------- core stub ----------------
   // mode 0: matching flag after kl+rl cycles, 1: never finishes, 2: raises only the other flag
   logic [63:0] st_blk;
   logic [79:0] st_key;
   logic        st_dir;
   int          st_kl, st_rl, st_mode;
   logic [63:0] st_res;

   initial begin
      int  n;
      logic fin;
      n = 0;
      uut_end_key_i = 1'b0; uut_end_enc_i = 1'b0; uut_end_dec_i = 1'b0; uut_block_i = '0;
      st_blk = '0; st_key = '0; st_dir = 1'b0; st_kl = 1; st_rl = 0; st_mode = 1; st_res = '0;
      forever begin
         @(posedge clk); #1;
         if (uut_rst_o) begin
            n = 0;
            uut_end_key_i = 1'b0; uut_end_enc_i = 1'b0; uut_end_dec_i = 1'b0; uut_block_i = '0;
         end else begin
            n++;
            if (n == 1) st_res = present_ref(st_blk, st_key, st_dir);
            fin = (st_mode != 1) && (n >= st_kl + st_rl);
            uut_end_key_i = (n >= st_kl);
            uut_end_enc_i = fin && ((st_mode == 0) ? !st_dir : st_dir);
            uut_end_dec_i = fin && ((st_mode == 0) ? st_dir : !st_dir);
            uut_block_i   = fin ? st_res : ~st_res;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   typedef struct {
      logic [63:0] blk;
      logic [79:0] key;
      logic        dir;
      int          kl;
      int          rl;
      int          mode;
      logic [63:0] exp_blk;
      logic        exp_to;
      int          exp_cyc;
   } vec_t;

   function automatic vec_t mk(input logic [63:0] blk, input logic [79:0] key, input logic dir,
                               input int kl, input int rl, input int mode,
                               input logic [63:0] eb, input logic et, input int ec);
      vec_t v;
      v.blk = blk; v.key = key; v.dir = dir; v.kl = kl; v.rl = rl; v.mode = mode;
      v.exp_blk = eb; v.exp_to = et; v.exp_cyc = ec;
      return v;
   endfunction

   // reference model: completion after kl+rl counted cycles unless that exceeds TIMEOUT
   function automatic vec_t model(input vec_t v);
      vec_t r;
      r = v;
      if (v.mode != 0 || v.kl + v.rl > TIMEOUT) begin
         r.exp_blk = '0; r.exp_to = 1'b1; r.exp_cyc = TIMEOUT;
      end else begin
         r.exp_blk = present_ref(v.blk, v.key, v.dir); r.exp_to = 1'b0; r.exp_cyc = v.kl + v.rl;
      end
      return r;
   endfunction

   task automatic do_txn(input vec_t v, input int hold);
      int w, rc, bad;
      logic [63:0] gb;
      logic [CNT_W-1:0] gc;
      logic gt, stable;
      st_blk = v.blk; st_key = v.key; st_dir = v.dir;
      st_kl = v.kl; st_rl = v.rl; st_mode = v.mode;
      w = 0;
      while (!req_ready_o && w < 50) begin @(posedge clk); #1; w++; end
      chk("req_ready_wait", {79'd0, req_ready_o}, 80'd1);
      req_valid_i = 1'b1; block_i = v.blk; key_i = v.key; enc_dec_i = v.dir;
      @(posedge clk); #1;
      req_valid_i = 1'b0; block_i = {$urandom, $urandom}; key_i = {$urandom, $urandom, $urandom};
      enc_dec_i = ~v.dir;
      chk("req_ready_busy", {79'd0, req_ready_o}, 80'd0);
      chk("uut_block", {16'd0, uut_block_o}, {16'd0, v.blk});
      chk("uut_key", uut_key_o, v.key);
      chk("uut_dir", {79'd0, uut_enc_dec_o}, {79'd0, v.dir});
      rc = 0;
      while (uut_rst_o && rc < 50) begin rc++; @(posedge clk); #1; end
      chk("uut_rst_len", 80'(rc), 80'(RST_CYCLES));
      w = 0; bad = 0;
      while (!rsp_valid_o && w < 200) begin
         if (uut_rst_o) bad++;
         w++; @(posedge clk); #1;
      end
      chk("rsp_valid_wait", {79'd0, rsp_valid_o}, 80'd1);
      chk("uut_rst_low", 80'(bad), 80'd0);
      chk("run_len", 80'(w), 80'(v.exp_cyc));
      gb = block_o; gc = cycles_o; gt = timeout_o;
      chk("block_o", {16'd0, gb}, {16'd0, v.exp_blk});
      chk("timeout_o", {79'd0, gt}, {79'd0, v.exp_to});
      chk("cycles_o", 80'(gc), 80'(v.exp_cyc));
      chk("uut_rst_done", {79'd0, uut_rst_o}, 80'd1);
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (!rsp_valid_o || block_o !== gb || cycles_o !== gc || timeout_o !== gt) stable = 1'b0;
      end
      if (hold > 0) chk("rsp_stable", {79'd0, stable}, 80'd1);
      rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      rsp_ready_i = 1'b0;
      chk("rsp_valid_drop", {79'd0, rsp_valid_o}, 80'd0);
      chk("idle_ready", {79'd0, req_ready_o}, 80'd1);
      chk("block_hold", {16'd0, block_o}, {16'd0, v.exp_blk});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   vec_t tbl [10];
   vec_t rv;

   initial begin
      logic [63:0] e0, e1;
      int w;
      logic seen;
      e0 = 64'h5579C1387B228445;
      e1 = 64'hE72C46C0F5945049;
      tbl[0] = mk(64'd0, 80'd0, 1'b0, 3, 4, 0, e0, 1'b0, 7);
      tbl[1] = mk(64'd0, '1, 1'b0, 2, 0, 0, e1, 1'b0, 2);
      tbl[2] = mk(e1, '1, 1'b1, 1, 5, 0, 64'd0, 1'b0, 6);
      tbl[3] = mk(64'h0123456789ABCDEF, 80'h1, 1'b0, 1, 0, 1, 64'd0, 1'b1, TIMEOUT);
      tbl[4] = mk(e0, 80'd0, 1'b1, 2, 3, 2, 64'd0, 1'b1, TIMEOUT);
      tbl[5] = mk(e0, 80'd0, 1'b1, 4, 3, 0, 64'd0, 1'b0, 7);
      tbl[6] = mk(64'd0, 80'd0, 1'b0, 10, 6, 0, e0, 1'b0, 16);
      tbl[7] = mk(64'd0, 80'd0, 1'b0, 10, 7, 0, 64'd0, 1'b1, TIMEOUT);
      tbl[8] = mk(64'd0, '1, 1'b0, 16, 0, 0, e1, 1'b0, 16);
      tbl[9] = mk(64'd0, '1, 1'b0, 17, 0, 0, 64'd0, 1'b1, TIMEOUT);

      rst = 1'b1; req_valid_i = 1'b0; block_i = '0; key_i = '0; enc_dec_i = 1'b0;
      rsp_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", {79'd0, req_ready_o}, 80'd1);
      chk("rst_rsp_valid", {79'd0, rsp_valid_o}, 80'd0);
      chk("rst_uut_rst", {79'd0, uut_rst_o}, 80'd1);
      chk("rst_outs", {block_o[15:0], cycles_o, 47'd0, timeout_o},
          80'd0);
      chk("rst_uut", {uut_block_o[63:0], 15'd0, uut_enc_dec_o}, 80'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (tbl[i]) do_txn(tbl[i], (i == 0) ? 10 : 1);

      for (int i = 0; i < 40; i++) begin
         rv.blk = {$urandom, $urandom};
         rv.key = {$urandom, $urandom, $urandom};
         rv.dir = 1'($urandom_range(0, 1));
         rv.kl = $urandom_range(1, 12);
         rv.rl = $urandom_range(0, 8);
         rv.mode = ($urandom_range(0, 7) == 0) ? 2 : 0;
         do_txn(model(rv), $urandom_range(0, 3));
      end

      // reset while the core is running: abort with no response
      st_mode = 1; st_kl = 1; st_rl = 0;
      req_valid_i = 1'b1; block_i = 64'hDEAD_BEEF_0000_1111; key_i = 80'h5; enc_dec_i = 1'b1;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("mid_run_active", {79'd0, uut_rst_o}, 80'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_ready", {79'd0, req_ready_o}, 80'd1);
      chk("mid_rst_uut_rst", {79'd0, uut_rst_o}, 80'd1);
      chk("mid_rst_outs", {block_o[63:0], cycles_o}, 80'd0);
      chk("mid_rst_uut", {uut_block_o, 15'd0, uut_enc_dec_o}, 80'd0);
      rsp_ready_i = 1'b1;
      seen = 1'b0;
      for (w = 0; w < 30; w++) begin
         @(posedge clk); #1;
         if (rsp_valid_o) seen = 1'b1;
      end
      rsp_ready_i = 1'b0;
      chk("mid_rst_no_rsp", {79'd0, seen}, 80'd0);

      do_txn(tbl[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
